ruler_result_collector: RTL and testbench

- Sits directly downstream of the last-mark (leaf) counter.
- Consumes its success flag, its position and the mark vector feeding it, and records each newly found Golomb ruler as the current best.
- Shrinks the search limit so that later rulers must be strictly shorter, and holds the search stalled via globalready while it updates.
- Detects exhaustion of the search and flags completion; the final recorded ruler is then the optimal one.

---
 rtl/ruler_result_collector_pkg.sv | 25 ++
 rtl/ruler_result_collector_edge.sv | 27 ++
 rtl/ruler_result_collector.sv | 125 ++++++++++++
 tb/tb_ruler_result_collector.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ruler_result_collector_pkg.sv
// Shared definitions for the Golomb ruler result collector: sizes, FSM encoding
// and the saturating solution counter helper.
package ruler_result_collector_pkg;

    localparam int NUMPOSITIONS   = 5;
    localparam int VALUE_WIDTH    = 8;
    localparam int LEVEL_WIDTH    = 4;
    localparam int COUNT_WIDTH    = 16;
    localparam int MAXVALUE       = (1 << VALUE_WIDTH) - 1;
    localparam int MAXLEVEL       = (1 << LEVEL_WIDTH) - 1;
    localparam int RESET_POSITION = 0;
    localparam int MARKS_WIDTH    = (NUMPOSITIONS + 1) * VALUE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PUBLISH = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/ruler_result_collector_edge.sv
// Leaf-ready rising-edge detector; qualifies a completion as a hit when the
// reported position is nonzero and within the current limit.
module ruler_edge_detect #(
    parameter int VALUE_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   leaf_ready_i,
    input  logic                   leaf_success_i,
    input  logic [VALUE_WIDTH-1:0] leaf_val_i,
    input  logic [VALUE_WIDTH-1:0] limit_i,
    output logic                   completion_o,
    output logic                   hit_o
);

    logic ready_q;

    // Resets high so a counter already ready at reset release is not seen as an edge.
    always_ff @(posedge clock) begin
        if (reset) ready_q <= 1'b1;
        else       ready_q <= leaf_ready_i;
    end

    assign completion_o = leaf_ready_i & ~ready_q;
    assign hit_o = completion_o & leaf_success_i & (leaf_val_i <= limit_i) & (leaf_val_i != '0);

endmodule

// File: rtl/ruler_result_collector.sv
// Records each Golomb ruler found by the leaf counter, tightens the search limit
// and stalls the search (globalready) while updating; flags exhaustion as done.
// Handshake: a leaf evaluation completes on the rising edge of leaf_ready; it is
// only acted upon in IDLE, and globalready is low whenever the FSM is not IDLE.
module ruler_result_collector
    import ruler_result_collector_pkg::*;
#(
    parameter int                     NUMPOSITIONS = ruler_result_collector_pkg::NUMPOSITIONS,
    parameter int                     VALUE_WIDTH  = ruler_result_collector_pkg::VALUE_WIDTH,
    parameter logic [VALUE_WIDTH-1:0] INIT_LIMIT   = VALUE_WIDTH'(255)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    leaf_ready,
    input  logic                                    leaf_success,
    input  logic [VALUE_WIDTH-1:0]                  leaf_val,
    input  logic [LEVEL_WIDTH-1:0]                  enabled,
    input  logic [(NUMPOSITIONS+1)*VALUE_WIDTH-1:0] marks_in,
    output logic                                    globalready,
    output logic [VALUE_WIDTH-1:0]                  limit,
    output logic [(NUMPOSITIONS+1)*VALUE_WIDTH-1:0] best_marks,
    output logic [VALUE_WIDTH-1:0]                  best_length,
    output logic [COUNT_WIDTH-1:0]                  solution_count,
    output logic                                    found,
    output logic                                    done,
    output state_t                                  dbg_state_o
);

    localparam int MW = (NUMPOSITIONS + 1) * VALUE_WIDTH;

    logic                   completion, hit;
    state_t                 state_q, state_d;
    logic                   gr_q, gr_d;
    logic [VALUE_WIDTH-1:0] limit_q, limit_d;
    logic [MW-1:0]          best_q, best_d;
    logic [MW-1:0]          shadow_q, shadow_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   found_q, found_d;
    logic                   done_q, done_d;

    ruler_edge_detect #(.VALUE_WIDTH(VALUE_WIDTH)) u_edge (
        .clock          (clock),
        .reset          (reset),
        .leaf_ready_i   (leaf_ready),
        .leaf_success_i (leaf_success),
        .leaf_val_i     (leaf_val),
        .limit_i        (limit_q),
        .completion_o   (completion),
        .hit_o          (hit)
    );

    always_comb begin
        state_d  = state_q;
        gr_d     = gr_q;
        limit_d  = limit_q;
        best_d   = best_q;
        shadow_d = shadow_q;
        count_d  = count_q;
        found_d  = found_q;
        done_d   = done_q;
        case (state_q)
            ST_IDLE: begin
                // A hit wins over exhaustion; exhaustion is re-checked after PUBLISH.
                if (hit) begin
                    shadow_d                   = marks_in;
                    shadow_d[VALUE_WIDTH-1:0]  = leaf_val;
                    gr_d                       = 1'b0;
                    state_d                    = ST_CAPTURE;
                end else if (enabled == '0 && leaf_ready) begin
                    gr_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                best_d  = shadow_q;
                found_d = 1'b1;
                count_d = sat_inc(count_q);
                state_d = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                limit_d = best_q[VALUE_WIDTH-1:0] - VALUE_WIDTH'(1);
                gr_d    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_DONE: begin
                gr_d   = 1'b0;
                done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gr_q     <= 1'b1;
            limit_q  <= INIT_LIMIT;
            best_q   <= '0;
            shadow_q <= '0;
            count_q  <= '0;
            found_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gr_q     <= gr_d;
            limit_q  <= limit_d;
            best_q   <= best_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
            found_q  <= found_d;
            done_q   <= done_d;
        end
    end

    assign globalready    = gr_q;
    assign limit          = limit_q;
    assign best_marks     = best_q;
    assign best_length    = best_q[VALUE_WIDTH-1:0];
    assign solution_count = count_q;
    assign found          = found_q;
    assign done           = done_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ruler_result_collector.sv
// Directed bench for ruler_result_collector with hand-computed expectations.
module tb_ruler_result_collector;
    import ruler_result_collector_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         leaf_ready;
    logic         leaf_success;
    logic [7:0]   leaf_val;
    logic [3:0]   enabled;
    logic [47:0]  marks_in;
    logic         globalready;
    logic [7:0]   limit;
    logic [47:0]  best_marks;
    logic [7:0]   best_length;
    logic [15:0]  solution_count;
    logic         found;
    logic         done;
    state_t       dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    ruler_result_collector #(.INIT_LIMIT(8'd24)) dut (
        .clock          (clock),
        .reset          (reset),
        .leaf_ready     (leaf_ready),
        .leaf_success   (leaf_success),
        .leaf_val       (leaf_val),
        .enabled        (enabled),
        .marks_in       (marks_in),
        .globalready    (globalready),
        .limit          (limit),
        .best_marks     (best_marks),
        .best_length    (best_length),
        .solution_count (solution_count),
        .found          (found),
        .done           (done),
        .dbg_state_o    (dbg_state)
    );

    always #5 clock = ~clock;

    // A completion during CAPTURE/PUBLISH must never be produced by the driver.
    logic tb_prev_ready = 1'b0;
    always @(posedge clock) begin
        if (!reset && leaf_ready && !tb_prev_ready &&
            (dbg_state == ST_CAPTURE || dbg_state == ST_PUBLISH)) begin
            n_bad++;
            $display("FAIL stall_assert: completion while state=%0d", dbg_state);
        end
        tb_prev_ready <= leaf_ready;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [47:0] pack6(input int a, b, c, d, e, f);
        return {a[7:0], b[7:0], c[7:0], d[7:0], e[7:0], f[7:0]};
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        leaf_ready   = 1'b0;
        leaf_success = 1'b0;
        leaf_val     = 8'd0;
        enabled      = 4'd5;
        marks_in     = '0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // Presents one leaf evaluation (rising leaf_ready) and returns one edge later.
    task automatic eval(input logic [47:0] m, input logic succ);
        marks_in     = m;
        leaf_val     = m[7:0];
        leaf_success = succ;
        leaf_ready   = 1'b1;
        tick(1);
        leaf_ready   = 1'b0;
        leaf_success = 1'b0;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        do_reset();
        check("rst_gr", globalready, 1);
        check("rst_limit", limit, 24);
        check("rst_count", solution_count, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // Reset while in CAPTURE.
        eval(pack6(0, 1, 4, 10, 12, 17), 1'b1);
        check("mid_state_cap", dbg_state, ST_CAPTURE);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_gr", globalready, 1);
        check("mid_limit", limit, 24);
        check("mid_best", best_marks, 0);
        check("mid_len", best_length, 0);
        check("mid_count", solution_count, 0);
        check("mid_found", found, 0);
        check("mid_done", done, 0);
        check("mid_state", dbg_state, ST_IDLE);
        tick(1);

        // Single hit with latency checks.
        eval(pack6(0, 1, 4, 10, 12, 17), 1'b1);
        check("h1_gr_e0", globalready, 0);
        check("h1_len_e0", best_length, 0);
        tick(1);
        check("h1_gr_e1", globalready, 0);
        check("h1_len", best_length, 17);
        check("h1_marks", best_marks, pack6(0, 1, 4, 10, 12, 17));
        check("h1_found", found, 1);
        check("h1_count", solution_count, 1);
        check("h1_limit_e1", limit, 24);
        tick(1);
        check("h1_limit", limit, 16);
        check("h1_gr_e2", globalready, 1);
        check("h1_state", dbg_state, ST_IDLE);

        // Stale success beyond the limit, and a zero position, are ignored.
        eval(pack6(0, 1, 4, 10, 12, 20), 1'b1);
        check("stale_gr", globalready, 1);
        tick(2);
        check("stale_limit", limit, 16);
        check("stale_count", solution_count, 1);
        check("stale_len", best_length, 17);
        eval(pack6(0, 0, 0, 0, 0, 0), 1'b1);
        tick(2);
        check("zero_count", solution_count, 1);
        // Failed evaluation within limit is not a hit either.
        eval(pack6(0, 1, 3, 7, 9, 12), 1'b0);
        tick(2);
        check("nosucc_count", solution_count, 1);

        // Two hits: limits 24 -> 21 -> 16.
        do_reset();
        eval(pack6(0, 1, 8, 11, 13, 22), 1'b1);
        tick(2);
        check("t1_limit", limit, 21);
        check("t1_len", best_length, 22);
        eval(pack6(0, 1, 4, 10, 12, 17), 1'b1);
        tick(2);
        check("t2_limit", limit, 16);
        check("t2_count", solution_count, 2);
        check("t2_len", best_length, 17);
        check("t2_marks", best_marks, pack6(0, 1, 4, 10, 12, 17));

        // Exhaustion: enabled==0 with leaf_ready high.
        enabled    = 4'd0;
        leaf_ready = 1'b1;
        tick(1);
        check("dn_done", done, 1);
        check("dn_gr", globalready, 0);
        check("dn_state", dbg_state, ST_DONE);
        check("dn_len", best_length, 17);
        check("dn_limit", limit, 16);
        leaf_ready = 1'b0;
        enabled    = 4'd5;
        tick(1);
        eval(pack6(0, 1, 3, 7, 9, 10), 1'b1);
        tick(3);
        check("dn_sticky", done, 1);
        check("dn_gr2", globalready, 0);
        check("dn_count", solution_count, 2);
        check("dn_marks", best_marks, pack6(0, 1, 4, 10, 12, 17));

        // Simultaneous hit and enabled==0: capture first, then DONE.
        do_reset();
        enabled = 4'd0;
        eval(pack6(0, 1, 8, 11, 13, 22), 1'b1);
        leaf_ready = 1'b1;
        tick(2);
        check("sim_count", solution_count, 1);
        check("sim_limit", limit, 21);
        check("sim_done_early", done, 0);
        tick(1);
        check("sim_done", done, 1);
        leaf_ready = 1'b0;
        enabled = 4'd5;

        // Saturation of solution_count.
        do_reset();
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        tick(1);
        eval(pack6(0, 1, 8, 11, 13, 20), 1'b1);
        tick(2);
        check("sat_1", solution_count, 16'hFFFF);
        eval(pack6(0, 1, 4, 10, 12, 18), 1'b1);
        tick(2);
        check("sat_2", solution_count, 16'hFFFF);
        eval(pack6(0, 1, 4, 9, 11, 15), 1'b1);
        tick(2);
        check("sat_3", solution_count, 16'hFFFF);
        check("sat_limit", limit, 14);
        check("sat_len", best_length, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
